// File: rtl/operand_gather8.sv
// Serial-to-parallel operand collector: packs eight WIDTH-bit words from a
// valid/ready stream into a held frame on a..h for the reduction stage.

module og8_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module operand_gather8 #(
  parameter int Port_Num = 2,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [2:0]       fill_cnt
);
  // Port_Num only mirrors the reduction stage's interface; slot count is fixed.
  localparam int NSLOT = 8 + 0 * Port_Num;

  logic [2:0]                  fill_q, fill_d;
  logic                        ovld_q, ovld_d;
  logic                        wr;
  logic [NSLOT-1:0]            slot_we;
  logic [NSLOT-1:0][WIDTH-1:0] slot_q;

  assign in_ready = !clr && (!ovld_q || out_ready);
  assign wr       = in_valid && in_ready;

  always_comb begin
    slot_we = '0;
    if (wr) slot_we[fill_q] = 1'b1;
  end

  always_comb begin
    fill_d = fill_q;
    ovld_d = ovld_q;
    if (clr) begin
      fill_d = '0;
      ovld_d = 1'b0;
    end else begin
      if (ovld_q && out_ready) ovld_d = 1'b0;
      if (wr) begin
        fill_d = 3'(fill_q + 3'd1);
        // Last slot written: frame complete; the wrap of fill_q restarts at a.
        if (fill_q == 3'd7) ovld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      ovld_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      ovld_q <= ovld_d;
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    og8_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (slot_we[i]),
      .d_i   (in_data),
      .q_o   (slot_q[i])
    );
  end

  assign a         = slot_q[0];
  assign b         = slot_q[1];
  assign c         = slot_q[2];
  assign d         = slot_q[3];
  assign e         = slot_q[4];
  assign f         = slot_q[5];
  assign g         = slot_q[6];
  assign h         = slot_q[7];
  assign out_valid = ovld_q;
  assign fill_cnt  = fill_q;
endmodule

// File: tb/tb_operand_gather8.sv
// Randomized + directed bench for operand_gather8 against a queue-based frame model.

module tb_operand_gather8;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic [2:0]   fill_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: words of the partial frame, last visible slot values, frame-held flag.
  logic [W-1:0] part[$];
  logic [W-1:0] m_slot[8];
  bit           m_ov;

  operand_gather8 #(.Port_Num(2), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_ov = 1'b0;
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
  endtask

  task automatic chk_state();
    logic [63:0] got, exp;
    got = 64'({a, b, c, d, e, f, g, h});
    exp = 64'({m_slot[0], m_slot[1], m_slot[2], m_slot[3],
               m_slot[4], m_slot[5], m_slot[6], m_slot[7]});
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("fill_cnt", 64'(fill_cnt), 64'(part.size()));
    chk("slots", got, exp);
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge, check state.
  task automatic step(input bit v, input logic [W-1:0] dat, input bit ordy, input bit cl);
    bit exp_rdy, acc;
    in_valid = v; in_data = dat; out_ready = ordy; clr = cl;
    #1;
    exp_rdy = !cl && (!m_ov || ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (cl) begin
      part.delete();
      m_ov = 1'b0;
    end else begin
      if (m_ov && ordy) m_ov = 1'b0;
      if (acc) begin
        m_slot[part.size()] = dat;
        part.push_back(dat);
        if (part.size() == 8) begin
          m_ov = 1'b1;
          part.delete();
        end
      end
    end
    #1;
    chk_state();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; checked before the next posedge.
  task automatic async_reset();
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_state();
    chk("in_ready_rst", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] pat[8];
    model_reset();
    #1;
    chk_state();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    // 1: all-ones frame, consumed immediately
    for (int i = 0; i < 8; i++) step(1, 7'h7F, 1, 0);
    chk("t1_a", 64'(a), 64'h7F);
    step(0, '0, 1, 0);

    // 2: walking-one frame held by backpressure
    pat = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h7F};
    for (int i = 0; i < 8; i++) step(1, pat[i], 0, 0);
    for (int i = 0; i < 5; i++) step(1, 7'h2A, 0, 0);
    chk("t2_h", 64'(h), 64'h7F);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // 3: back-to-back frames, zero bubble
    for (int i = 0; i < 16; i++) step(1, W'(i), 1, 0);
    chk("t3_a", 64'(a), 64'd8);
    step(0, '0, 1, 0);

    // 4: clr aborts a partial frame and blocks the word in that cycle
    step(1, 7'h11, 1, 0); step(1, 7'h22, 1, 0); step(1, 7'h33, 1, 0);
    step(1, 7'h55, 1, 1);
    for (int i = 0; i < 8; i++) step(1, W'(7'h60 + i), 1, 0);
    step(0, '0, 1, 0);

    // 5: clr discards a held frame
    for (int i = 0; i < 8; i++) step(1, W'(7'h70 + i), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 1, 1);
    step(0, '0, 0, 0);

    // 6: async reset mid-frame, then first word lands in a
    for (int i = 0; i < 5; i++) step(1, W'(7'h0A + i), 1, 0);
    async_reset();
    step(1, 7'h5A, 1, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step(bit'($urandom_range(0, 3) != 0), W'($urandom),
                bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/operand_gather8.md
Name: operand_gather8

Overview:
- Serial-to-parallel operand collector.
- Accepts WIDTH-bit words one at a time over a valid/ready stream and assembles them into an 8-operand frame on parallel outputs a..h.
- Sits directly upstream of the 8-port reduction stage, whose a..h inputs it drives; holds each frame stable until the downstream consumer accepts it.

Parameters:
- Port_Num, 2, carried for interface compatibility with the reduction stage; no functional effect.
- WIDTH, 8, operand width in bits (bench runs WIDTH=7).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous frame abort; drops any partial or held frame
- in_valid  input  1  in_data holds a word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  operand word
- out_valid  output  1  a..h hold a complete frame
- out_ready  input  1  downstream accepts the frame this cycle
- a,b,c,d,e,f,g,h  output  WIDTH each  frame slots 0..7, registered
- fill_cnt  output  3  number of words captured in the current partial frame

Behaviour:
- Reset: rst_n low asynchronously forces fill_cnt=0, out_valid=0, a..h=0. in_ready is 1 after release.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Input handshake:
  - in_ready = !clr && (!out_valid || out_ready), combinational.
  - A word transfers on any rising edge with in_valid && in_ready.
- Slot writes:
  - Accepted word goes to slot fill_cnt (0→a, 1→b … 7→h), then fill_cnt increments.
  - On the word written at fill_cnt=7, fill_cnt wraps to 0 and out_valid is 1 from the next cycle.
  - Latency: 8th word accepted at edge N → out_valid=1 after edge N.
- Output handshake:
  - While out_valid && !out_ready, a..h and out_valid are held stable and in_ready=0.
  - Frame transfers on an edge with out_valid && out_ready; out_valid clears after that edge.
- Simultaneous transfer: if an input transfer coincides with the output transfer, the new word is written to slot a and fill_cnt becomes 1. Zero bubble; sustained throughput is one frame per 8 cycles.
- Unwritten slots: slots not yet overwritten in a partial frame keep previous-frame values. They are meaningful only while out_valid=1.
- Input stalls: in_valid low mid-frame holds fill_cnt and slots indefinitely; there is no timeout.
- clr (sync, highest priority):
  - Next edge forces fill_cnt=0 and out_valid=0; slot contents are unchanged.
  - in_ready=0 during the clr cycle, so no word is captured.
  - A held frame is discarded even if out_ready=1 that cycle; downstream must not count it.
- Reset mid-frame: all state is discarded immediately. The first accepted word after release goes to slot a.
- No arithmetic: data passes bit-exact, with no width change.

Test Plan:
1. Reset then stream 8 words 7'h7F with in_valid=1, out_ready=1 → out_valid=1 for exactly one cycle after 8th edge, a..h all 7'h7F, fill_cnt back to 0.
2. Stream 7'h01,02,04,08,10,20,40,7F with out_ready=0 for 5 cycles after completion → a..h hold these values in order, out_valid stays 1, in_ready=0. On out_ready=1, out_valid drops next cycle.
3. Back-to-back frames, in_valid=1 continuously, out_ready=1, 16 words 0..15 → frame1 a..h=0..7, frame2 a..h=8..15. No cycle with in_ready=0; word 8 lands in a on the same edge frame1 transfers.
4. Write 3 words (7'h11,22,33), assert clr one cycle with in_valid=1, in_data=7'h55 → 7'h55 not captured, fill_cnt=0. Next 8 words form a clean frame starting in a.
5. Complete a frame, hold out_ready=0, pulse clr → out_valid=0 next cycle, in_ready=1, a..h unchanged.
6. Write 5 words, pull rst_n low mid-cycle asynchronously → a..h=0, fill_cnt=0, out_valid=0 before the next clk edge.
